// File: rtl/uart_tx_wb.sv
// Wishbone-fed 8N1 UART transmitter: bytes queue in a FIFO and tx_o falls one clock after a TXDATA accept when idle.
// Never stalls the bus; one registered ack/err per accept; TXDATA writes while full are dropped with err.
module uart_tx_wb #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_stall_o,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_err_o,
    output logic        tx_o,
    output logic        tx_empty_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e        state_q, state_d;
    logic [15:0]   baud_q, baud_d, div_q, div_d, cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          ack_q, err_q;
    logic [31:0]   dat_q, rd_data;
    logic [1:0]    reg_sel;
    logic [7:0]    count8;
    logic          accept, fifo_full, fifo_empty, push, pop, busy, bad_access, bit_done;
    logic          unused_bits;

    assign accept     = wb_cyc_i & wb_stb_i;
    assign reg_sel    = wb_adr_i[3:2];
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign busy       = (state_q != S_IDLE);
    assign count8     = 8'(count_q);
    assign bit_done   = (cnt_q == div_q);
    assign push       = accept & wb_we_i & (reg_sel == 2'd0) & wb_sel_i[0] & ~fifo_full;
    assign bad_access = (reg_sel == 2'd3) | (wb_we_i & (reg_sel == 2'd0) & wb_sel_i[0] & fifo_full);
    assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd1:    rd_data = {16'h0, count8, 5'h0, busy, fifo_empty, fifo_full};
            2'd2:    rd_data = {16'h0, baud_q};
            default: rd_data = '0;
        endcase
    end

    always_comb begin
        baud_d = baud_q;
        if (accept && wb_we_i && reg_sel == 2'd2) begin
            if (wb_sel_i[0]) baud_d[7:0]  = wb_dat_i[7:0];
            if (wb_sel_i[1]) baud_d[15:8] = wb_dat_i[15:8];
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            dat_q  <= '0;
            baud_q <= DEFAULT_DIV;
        end else begin
            ack_q  <= accept & ~bad_access;
            err_q  <= accept & bad_access;
            dat_q  <= (accept & ~bad_access & ~wb_we_i) ? rd_data : '0;
            baud_q <= baud_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wptr_q] <= wb_dat_i[7:0];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            div_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            tx_q    <= tx_d;
        end
    end

    // The divisor is captured when a byte is popped, so BAUDDIV writes only affect later frames.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        div_d   = div_q;
        tx_d    = tx_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_START;
                    shift_d = mem_q[rptr_q];
                    div_d   = baud_q;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (pop) begin
                        state_d = S_START;
                        shift_d = mem_q[rptr_q];
                        div_d   = baud_q;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop = 1'b0;
        case (state_q)
            S_IDLE:  pop = ~fifo_empty;
            S_STOP:  pop = bit_done & ~fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    assign tx_empty_o = fifo_empty & ~busy;
    assign tx_o       = tx_q;
    assign wb_stall_o = 1'b0;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign wb_dat_o   = dat_q;

endmodule

// File: tb/tb_uart_tx_wb.sv
// Bench for uart_tx_wb: directed and random Wishbone traffic checked cycle by cycle against a frame-level model.
module tb_uart_tx_wb;
    localparam int          DEPTH   = 8;
    localparam logic [15:0] DEF_DIV = 16'd867;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i  = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_stall_o, wb_ack_o, wb_err_o, tx_o, tx_empty_o;
    logic [31:0] wb_dat_o;

    uart_tx_wb #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DEF_DIV)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_stall_o(wb_stall_o), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o), .wb_err_o(wb_err_o),
        .tx_o(tx_o), .tx_empty_o(tx_empty_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_vec = 0;
    int n_bad = 0;
    int t = 0;

    // Model: queued bytes plus the one frame currently on the line.
    logic [7:0]  q_m[$];
    logic        fr_act;
    int          fr_start, fr_div, fr_end;
    logic [7:0]  fr_byte;
    logic [15:0] baud_m;
    logic        exp_ack, exp_err;
    logic [31:0] exp_dat;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, got, exp, t);
        end
    endtask

    function automatic logic line_busy();
        return fr_act && (t < fr_end);
    endfunction

    function automatic logic model_tx();
        int p;
        if (line_busy()) begin
            p = (t - fr_start) / (fr_div + 1);
            if (p == 0) return 1'b0;
            if (p <= 8) return fr_byte[p-1];
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        q_m.delete();
        fr_act  = 1'b0;
        baud_m  = DEF_DIV;
        exp_ack = 1'b0;
        exp_err = 1'b0;
        exp_dat = '0;
    endtask

    task automatic model_edge(input logic acc, input logic we, input logic [1:0] a,
                              input logic [31:0] dat, input logic [3:0] sel);
        int          sz;
        logic        full_b, busy_b;
        logic [15:0] baud_b;
        t++;
        sz     = q_m.size();
        full_b = (sz == DEPTH);
        busy_b = fr_act && (t - 1 < fr_end);
        baud_b = baud_m;
        if ((!fr_act || t >= fr_end) && sz > 0) begin
            fr_byte  = q_m.pop_front();
            fr_act   = 1'b1;
            fr_start = t;
            fr_div   = int'(baud_b);
            fr_end   = t + 10 * (fr_div + 1);
        end
        exp_ack = 1'b0;
        exp_err = 1'b0;
        exp_dat = '0;
        if (acc) begin
            case (a)
                2'd0: begin
                    if (we && sel[0]) begin
                        if (full_b) exp_err = 1'b1;
                        else begin
                            exp_ack = 1'b1;
                            q_m.push_back(dat[7:0]);
                        end
                    end else exp_ack = 1'b1;
                end
                2'd1: begin
                    exp_ack = 1'b1;
                    if (!we) exp_dat = {16'h0, 8'(sz), 5'h0, busy_b, (sz == 0), full_b};
                end
                2'd2: begin
                    exp_ack = 1'b1;
                    if (we) begin
                        if (sel[0]) baud_m[7:0]  = dat[7:0];
                        if (sel[1]) baud_m[15:8] = dat[15:8];
                    end else exp_dat = {16'h0, baud_b};
                end
                default: exp_err = 1'b1;
            endcase
        end
    endtask

    task automatic compare_outputs();
        check_eq("ack", 32'(wb_ack_o), 32'(exp_ack));
        check_eq("err", 32'(wb_err_o), 32'(exp_err));
        check_eq("dat", wb_dat_o, exp_dat);
        check_eq("tx", 32'(tx_o), 32'(model_tx()));
        check_eq("tx_empty", 32'(tx_empty_o), 32'(q_m.size() == 0 && !line_busy()));
        check_eq("stall", 32'(wb_stall_o), 32'h0);
    endtask

    task automatic bus_cycle(input logic cyc, input logic stb, input logic we,
                             input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_cyc_i = cyc;
        wb_stb_i = stb;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        @(posedge wb_clk_i);
        model_edge(cyc & stb, we, adr[3:2], dat, sel);
        #1;
        compare_outputs();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bus_cycle(1'b1, 1'b1, 1'b1, adr, dat, sel);
    endtask

    task automatic wb_read(input logic [31:0] adr);
        bus_cycle(1'b1, 1'b1, 1'b0, adr, 32'h0, 4'hF);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic apply_reset();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_rst_i = 1'b1;
        #1;
        check_eq("rst_tx", 32'(tx_o), 32'h1);
        check_eq("rst_ack", 32'(wb_ack_o), 32'h0);
        check_eq("rst_err", 32'(wb_err_o), 32'h0);
        check_eq("rst_dat", wb_dat_o, 32'h0);
        check_eq("rst_empty", 32'(tx_empty_o), 32'h1);
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [3:0]  sel;
        logic [31:0] adr;
        int          r;
        model_reset();
        #1;
        apply_reset();

        wb_read(32'h4);
        wb_read(32'h8);
        idle(2);

        wb_write(32'h8, 32'd3, 4'h3);
        wb_write(32'h0, 32'hA5, 4'h1);
        idle(45);

        wb_write(32'h8, 32'd0, 4'h3);
        for (int i = 0; i < 9; i++) wb_write(32'h0, 32'($urandom_range(0, 255)), 4'h1);
        idle(100);

        wb_write(32'hC, 32'h55, 4'hF);
        wb_read(32'hC);
        wb_write(32'h0, 32'hFF, 4'b1110);
        wb_read(32'h4);
        wb_read(32'h8);

        wb_write(32'h8, 32'd3, 4'h3);
        wb_write(32'h0, 32'($urandom_range(0, 255)), 4'h1);
        wb_write(32'h0, 32'($urandom_range(0, 255)), 4'h1);
        idle(10);
        wb_write(32'h8, 32'd7, 4'h3);
        idle(130);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            sel = 4'($urandom_range(0, 15));
            adr = {24'($urandom_range(0, 255)), 4'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            case (r)
                0, 1:    idle(1);
                2:       bus_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b1, 32'h0, 32'h41, 4'h1);
                3, 4:    wb_write(32'h0, 32'($urandom), sel | 4'h1);
                5:       wb_write(32'h0, 32'($urandom), sel);
                6:       wb_write(32'h8, 32'($urandom_range(0, 3)), sel);
                7, 8:    wb_read(adr);
                default: wb_write({adr[31:4], ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd1, 2'd0},
                                  32'($urandom), sel);
            endcase
        end
        for (int i = 0; i < 3000 && (q_m.size() != 0 || line_busy()); i++) idle(1);
        check_eq("drain_empty", 32'(tx_empty_o), 32'h1);

        wb_write(32'h8, 32'd3, 4'h3);
        wb_write(32'h0, 32'h00, 4'h1);
        idle(8);
        apply_reset();
        wb_read(32'h4);
        wb_read(32'h8);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
